// File: rtl/wino_pass_scheduler_pkg.sv
// Shared types and constants for the Winograd pass scheduler: FSM states,
// datapath widths and the per-pass FIFO direction flags.
package wino_pass_scheduler_pkg;

  localparam int TILE_W     = 11;
  localparam int GRP_W      = 8;
  localparam int FIFO_DEPTH = 1024;
  localparam int MIN_PASS   = 4;
  localparam int PERF_W     = 32;
  localparam int CNT_W      = TILE_W + GRP_W;
  localparam int PASS_W     = $clog2(MIN_PASS + 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // {tofifo, fromfifo}: every pass but the last writes the FIFO, every pass but the first reads it
  function automatic logic [1:0] pass_flags(input logic [GRP_W-1:0] grp,
                                            input logic [GRP_W-1:0] groups);
    logic [GRP_W-1:0] last_grp;
    last_grp = groups - GRP_W'(1'b1);
    return {(grp != last_grp), (grp != {GRP_W{1'b0}})};
  endfunction

endpackage

// File: rtl/wino_out_tagger.sv
// Counts core outputs of the running job and marks those that belong to the
// final accumulation pass.
module wino_out_tagger
  import wino_pass_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              busy,
  input  logic [TILE_W-1:0] tiles,
  input  logic [GRP_W-1:0]  groups,
  input  logic              pe_out_valid,
  output logic              res_keep,
  output logic              drained
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] tiles_x_s;
  logic [CNT_W-1:0] groups_x_s;
  logic [CNT_W-1:0] total_s;
  logic [CNT_W-1:0] keep_base_s;

  // job totals: all outputs, and the index where the final pass begins
  always_comb begin
    tiles_x_s   = CNT_W'(tiles);
    groups_x_s  = CNT_W'(groups);
    total_s     = tiles_x_s * groups_x_s;
    keep_base_s = tiles_x_s * (groups_x_s - CNT_W'(1'b1));
  end

  // output counter, restarted on job acceptance; strays outside a job are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (busy && pe_out_valid) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign res_keep = pe_out_valid & busy & (count_r >= keep_base_s);
  assign drained  = (count_r >= total_s);

endmodule

// File: rtl/wino_pass_scheduler.sv
// Sequences one Winograd PE job: T tiles per pass, G channel-group passes.
// Optional performance counters are built when WINO_SCHED_PERF_EN is defined.
module wino_pass_scheduler
  import wino_pass_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [GRP_W-1:0]  cfg_groups,
  input  logic              cfg_poolop,
  output logic              cfg_err,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [TILE_W-1:0] issue_tile,
  output logic [GRP_W-1:0]  issue_group,
  output logic              pe_in_valid,
  output logic              pe_tofifo,
  output logic              pe_fromfifo,
  output logic              pe_bias_valid,
  output logic              pe_poolop,
  input  logic              pe_out_valid,
  output logic              res_keep,
  output logic              busy,
  output logic              done
`ifdef WINO_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_busy_cyc,
  output logic [PERF_W-1:0] perf_stall_cyc
`endif
);

  state_e            state_r, next_state_s;
  logic [TILE_W-1:0] tiles_r, tile_r;
  logic [GRP_W-1:0]  groups_r, grp_r;
  logic              pool_r;
  logic [PASS_W-1:0] pass_cyc_r;

  logic cfg_ready_r, cfg_err_r, issue_valid_r, in_valid_r, tofifo_r, fromfifo_r;
  logic bias_r, poolop_r, busy_r, done_r;
  logic cfg_ready_d, cfg_err_d, issue_valid_d, in_valid_d, tofifo_d, fromfifo_d;
  logic bias_d, poolop_d, busy_d, done_d;

  logic       accept_s, cfg_bad_s, hs_s, last_tile_s, last_grp_s;
  logic       pass_met_s, new_pass_s, drained_s;
  logic [1:0] flags_s;

  assign accept_s    = cfg_valid & cfg_ready_r;
  assign cfg_bad_s   = (cfg_tiles == {TILE_W{1'b0}}) | (cfg_groups == {GRP_W{1'b0}}) |
                       (cfg_tiles > TILE_W'(FIFO_DEPTH));
  assign hs_s        = issue_valid_r & issue_ready;
  assign last_tile_s = (tile_r == tiles_r - TILE_W'(1'b1));
  assign last_grp_s  = (grp_r == groups_r - GRP_W'(1'b1));
  // the next pass may start once MIN_PASS cycles have passed since this pass's first issue
  assign pass_met_s  = (pass_cyc_r + PASS_W'(1'b1)) >= PASS_W'(MIN_PASS);
  assign new_pass_s  = (next_state_s == ST_ISSUE) &
                       ((state_r != ST_ISSUE) | (hs_s & last_tile_s));
  assign flags_s     = pass_flags(grp_r, groups_r);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !cfg_bad_s) next_state_s = ST_BIAS;
        else                        next_state_s = ST_IDLE;
      end
      ST_BIAS: next_state_s = ST_ISSUE;
      ST_ISSUE: begin
        if (hs_s && last_tile_s) begin
          if (last_grp_s)       next_state_s = ST_DRAIN;
          else if (!pass_met_s) next_state_s = ST_GAP;
          else                  next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_GAP: begin
        if (pass_met_s) next_state_s = ST_ISSUE;
        else            next_state_s = ST_GAP;
      end
      ST_DRAIN: begin
        if (drained_s) next_state_s = ST_DONE;
        else           next_state_s = ST_DRAIN;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // output decode from the next state, so every output leaves a flop
  always_comb begin
    cfg_ready_d   = (next_state_s == ST_IDLE);
    busy_d        = (next_state_s != ST_IDLE);
    issue_valid_d = (next_state_s == ST_ISSUE);
    bias_d        = (next_state_s == ST_BIAS);
    done_d        = (next_state_s == ST_DONE);
    cfg_err_d     = accept_s & cfg_bad_s;
    poolop_d      = busy_d & (accept_s ? cfg_poolop : pool_r);
    in_valid_d    = hs_s;
    tofifo_d      = 1'b0;
    fromfifo_d    = 1'b0;
    if (hs_s) begin
      tofifo_d   = flags_s[1];
      fromfifo_d = flags_s[0];
    end else begin
      tofifo_d   = 1'b0;
      fromfifo_d = 1'b0;
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready_r   <= 1'b0;
      cfg_err_r     <= 1'b0;
      issue_valid_r <= 1'b0;
      in_valid_r    <= 1'b0;
      tofifo_r      <= 1'b0;
      fromfifo_r    <= 1'b0;
      bias_r        <= 1'b0;
      poolop_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      cfg_ready_r   <= cfg_ready_d;
      cfg_err_r     <= cfg_err_d;
      issue_valid_r <= issue_valid_d;
      in_valid_r    <= in_valid_d;
      tofifo_r      <= tofifo_d;
      fromfifo_r    <= fromfifo_d;
      bias_r        <= bias_d;
      poolop_r      <= poolop_d;
      busy_r        <= busy_d;
      done_r        <= done_d;
    end
  end

  // job configuration, tile/group position and pass-age counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tiles_r    <= {TILE_W{1'b0}};
      groups_r   <= {GRP_W{1'b0}};
      pool_r     <= 1'b0;
      tile_r     <= {TILE_W{1'b0}};
      grp_r      <= {GRP_W{1'b0}};
      pass_cyc_r <= {PASS_W{1'b0}};
    end else begin
      if (accept_s) begin
        tiles_r  <= cfg_tiles;
        groups_r <= cfg_groups;
        pool_r   <= cfg_poolop;
        tile_r   <= {TILE_W{1'b0}};
        grp_r    <= {GRP_W{1'b0}};
      end else if (hs_s) begin
        if (last_tile_s) begin
          tile_r <= {TILE_W{1'b0}};
          grp_r  <= last_grp_s ? {GRP_W{1'b0}} : grp_r + GRP_W'(1'b1);
        end else begin
          tile_r <= tile_r + TILE_W'(1'b1);
          grp_r  <= grp_r;
        end
      end else begin
        tile_r <= tile_r;
        grp_r  <= grp_r;
      end
      if (new_pass_s) begin
        pass_cyc_r <= {PASS_W{1'b0}};
      end else if (pass_cyc_r < PASS_W'(MIN_PASS)) begin
        pass_cyc_r <= pass_cyc_r + PASS_W'(1'b1);
      end else begin
        pass_cyc_r <= pass_cyc_r;
      end
    end
  end

  wino_out_tagger u_tagger (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept_s),
    .busy         (busy_r),
    .tiles        (tiles_r),
    .groups       (groups_r),
    .pe_out_valid (pe_out_valid),
    .res_keep     (res_keep),
    .drained      (drained_s)
  );

`ifdef WINO_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_busy_r, perf_stall_r;

  // saturating busy/stall counters, restarted on job acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_r  <= {PERF_W{1'b0}};
      perf_stall_r <= {PERF_W{1'b0}};
    end else if (accept_s) begin
      perf_busy_r  <= {PERF_W{1'b0}};
      perf_stall_r <= {PERF_W{1'b0}};
    end else begin
      if (busy_r && !(&perf_busy_r)) perf_busy_r <= perf_busy_r + PERF_W'(1'b1);
      else                           perf_busy_r <= perf_busy_r;
      if ((state_r == ST_ISSUE) && issue_valid_r && !issue_ready && !(&perf_stall_r))
        perf_stall_r <= perf_stall_r + PERF_W'(1'b1);
      else
        perf_stall_r <= perf_stall_r;
    end
  end

  assign perf_busy_cyc  = perf_busy_r;
  assign perf_stall_cyc = perf_stall_r;
`endif

  assign cfg_ready     = cfg_ready_r;
  assign cfg_err       = cfg_err_r;
  assign issue_valid   = issue_valid_r;
  assign issue_tile    = tile_r;
  assign issue_group   = grp_r;
  assign pe_in_valid   = in_valid_r;
  assign pe_tofifo     = tofifo_r;
  assign pe_fromfifo   = fromfifo_r;
  assign pe_bias_valid = bias_r;
  assign pe_poolop     = poolop_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_wino_pass_scheduler.sv
// Testbench for wino_pass_scheduler: directed and randomized jobs checked
// against a tile/pass model and an emulated core with fixed output latency.
module tb_wino_pass_scheduler;
  import wino_pass_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, cfg_valid, cfg_poolop, issue_ready, pe_out_valid;
  logic [TILE_W-1:0] cfg_tiles;
  logic [GRP_W-1:0]  cfg_groups;
  logic              cfg_ready, cfg_err, issue_valid, pe_in_valid, pe_tofifo, pe_fromfifo;
  logic              pe_bias_valid, pe_poolop, res_keep, busy, done;
  logic [TILE_W-1:0] issue_tile;
  logic [GRP_W-1:0]  issue_group;
`ifdef WINO_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_busy_cyc, perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  wino_pass_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tiles(cfg_tiles),
    .cfg_groups(cfg_groups), .cfg_poolop(cfg_poolop), .cfg_err(cfg_err),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tile(issue_tile),
    .issue_group(issue_group), .pe_in_valid(pe_in_valid), .pe_tofifo(pe_tofifo),
    .pe_fromfifo(pe_fromfifo), .pe_bias_valid(pe_bias_valid), .pe_poolop(pe_poolop),
    .pe_out_valid(pe_out_valid), .res_keep(res_keep), .busy(busy), .done(done)
`ifdef WINO_SCHED_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int ready_mode = 0;
  int acc_cyc = 0;
  bit job_pool = 1'b0;
  logic [2:0] pipe = 3'b000;

  int hs_tile[$], hs_grp[$], hs_cyc[$], in_cyc[$], out_cyc[$], bias_cyc[$];
  logic [1:0] in_flags[$];
  bit out_keep[$];
  int done_cnt, done_cyc, err_cnt, pool_bad, rdy_busy_bad, stray_keep;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    hs_tile.delete(); hs_grp.delete(); hs_cyc.delete(); in_cyc.delete();
    out_cyc.delete(); bias_cyc.delete(); in_flags.delete(); out_keep.delete();
    done_cnt = 0; done_cyc = 0; err_cnt = 0; pool_bad = 0; rdy_busy_bad = 0; stray_keep = 0;
  endtask

  // one clock: observe registered outputs, emulate the core, drive buffers
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    if (pe_in_valid === 1'b1) begin
      in_cyc.push_back(cyc_n);
      in_flags.push_back({pe_tofifo, pe_fromfifo});
    end
    if (pe_bias_valid === 1'b1) bias_cyc.push_back(cyc_n);
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc_n; end
    if (cfg_err === 1'b1) err_cnt++;
    if (pe_poolop !== (busy & job_pool)) pool_bad++;
    if (busy === 1'b1 && cfg_ready === 1'b1) rdy_busy_bad++;
    pipe = {pipe[1:0], (pe_in_valid === 1'b1) & rst_n};
    pe_out_valid = pipe[2];
    case (ready_mode)
      0:       issue_ready = 1'b1;
      1:       issue_ready = cyc_n[0];
      default: issue_ready = 1'($urandom_range(0, 1));
    endcase
    if (issue_valid === 1'b1 && issue_ready) begin
      hs_tile.push_back(int'(issue_tile));
      hs_grp.push_back(int'(issue_group));
      hs_cyc.push_back(cyc_n);
    end
    #1;
    if (pe_out_valid) begin
      out_keep.push_back(res_keep === 1'b1);
      out_cyc.push_back(cyc_n);
    end else if (res_keep !== 1'b0) begin
      stray_keep++;
    end
  endtask

  task automatic start_job(input int t, input int g, input bit pool, input int mode);
    clear_log();
    job_pool = pool;
    ready_mode = mode;
    for (int i = 0; i < 50 && cfg_ready !== 1'b1; i++) tick();
    check("cfg_ready_before_job", cfg_ready, 1);
    cfg_tiles = TILE_W'(t);
    cfg_groups = GRP_W'(g);
    cfg_poolop = pool;
    cfg_valid = 1'b1;
    acc_cyc = cyc_n;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic finish_job(input int t, input int g, input int mode);
    int n, bad, last_out, pg, sp;
    n = t * g;
    for (int i = 0; i < n * 6 + 100 && done_cnt == 0; i++) tick();
    check("done_seen", done_cnt, 1);
    check("bias_count", bias_cyc.size(), 1);
    check("bias_cycle", (bias_cyc.size() > 0) ? bias_cyc[0] : -1, acc_cyc + 1);
    check("issue_count", hs_tile.size(), n);
    check("in_valid_count", in_cyc.size(), n);
    bad = 0;
    for (int k = 0; k < hs_tile.size() && k < n; k++)
      if (hs_tile[k] != k % t || hs_grp[k] != k / t) bad++;
    check("tile_order", bad, 0);
    bad = 0;
    for (int k = 0; k < n && k < in_cyc.size() && k < hs_cyc.size(); k++) begin
      pg = k / t;
      if (in_cyc[k] != hs_cyc[k] + 1) bad++;
      if (in_flags[k] !== {pg < g - 1, pg > 0}) bad++;
      if (k >= t && in_cyc[k] <= in_cyc[k - t]) bad++;
    end
    check("in_valid_flags", bad, 0);
    if (mode == 0 && hs_cyc.size() >= n) begin
      bad = 0;
      sp = (t > MIN_PASS) ? t : MIN_PASS;
      for (int p = 1; p < g; p++)
        if (hs_cyc[p * t] - hs_cyc[(p - 1) * t] != sp) bad++;
      check("pass_spacing", bad, 0);
    end
    check("out_count", out_keep.size(), n);
    bad = 0;
    for (int k = 0; k < out_keep.size(); k++)
      if (out_keep[k] != (k >= t * (g - 1))) bad++;
    check("res_keep_pattern", bad, 0);
    last_out = (out_cyc.size() > 0) ? out_cyc[out_cyc.size() - 1] : 0;
    check("done_after_last_out", (done_cyc > last_out) ? 1 : 0, 1);
    check("poolop_track", pool_bad, 0);
    check("cfg_ready_while_busy", rdy_busy_bad, 0);
    check("cfg_err_during_job", err_cnt, 0);
    check("keep_without_valid", stray_keep, 0);
    tick();
    check("idle_after_done", {busy, cfg_ready, issue_valid, done}, 4'b0100);
  endtask

  task automatic bad_cfg(input int t, input int g, input string tag);
    for (int i = 0; i < 50 && cfg_ready !== 1'b1; i++) tick();
    cfg_tiles = TILE_W'(t);
    cfg_groups = GRP_W'(g);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check({tag, "_err_pulse"}, {cfg_err, busy, pe_bias_valid}, 3'b100);
    tick();
    check({tag, "_stays_idle"}, {cfg_err, cfg_ready, busy}, 3'b010);
  endtask

  initial begin
    int t, g;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_poolop = 1'b0; issue_ready = 1'b0;
    pe_out_valid = 1'b0; cfg_tiles = '0; cfg_groups = '0;
    clear_log();
    repeat (3) tick();
    check("reset_outputs", {cfg_ready, cfg_err, issue_valid, pe_in_valid, pe_tofifo, pe_fromfifo,
                            pe_bias_valid, pe_poolop, busy, done, res_keep, issue_tile, issue_group}, 0);
    rst_n = 1'b1;
    tick();
    check("cfg_ready_after_reset", {cfg_ready, busy}, 2'b10);

    pe_out_valid = 1'b1;
    #1;
    check("stray_idle_keep", res_keep, 0);
    pe_out_valid = 1'b0;

    start_job(4, 1, 1'b0, 0);  finish_job(4, 1, 0);
    start_job(8, 3, 1'b1, 0);  finish_job(8, 3, 0);
    start_job(1, 3, 1'b0, 0);  finish_job(1, 3, 0);
    start_job(16, 2, 1'b1, 1); finish_job(16, 2, 1);

    bad_cfg(0, 2, "tiles_zero");
    bad_cfg(1025, 1, "tiles_over_depth");
    bad_cfg(3, 0, "groups_zero");

    // a configuration offered mid-job must wait for IDLE, then be judged on its own
    start_job(4, 2, 1'b0, 0);
    cfg_tiles = '0; cfg_groups = GRP_W'(1); cfg_valid = 1'b1;
    finish_job(4, 2, 0);
    tick();
    check("held_cfg_after_done", cfg_err, 1);
    cfg_valid = 1'b0;
    tick();
    check("held_cfg_err_one_cycle", {cfg_err, busy}, 2'b00);

    start_job(8, 3, 1'b1, 0);
    for (int i = 0; i < 60 && hs_tile.size() < 12; i++) tick();
    check("reached_pass2", (hs_tile.size() >= 12) ? 1 : 0, 1);
    rst_n = 1'b0;
    pipe = 3'b000;
    pe_out_valid = 1'b0;
    tick();
    check("midjob_reset_outputs", {pe_in_valid, pe_tofifo, pe_fromfifo, pe_bias_valid, pe_poolop,
                                   busy, issue_valid, done, cfg_ready}, 0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (30) tick();
    check("no_done_after_reset", {done_cnt[7:0], busy}, 0);
    start_job(8, 3, 1'b0, 2); finish_job(8, 3, 2);

    for (int j = 0; j < 5; j++) begin
      t = int'($urandom_range(1, 12));
      g = int'($urandom_range(1, 5));
      start_job(t, g, 1'($urandom_range(0, 1)), (j == 0) ? 0 : 2);
      finish_job(t, g, (j == 0) ? 0 : 2);
    end

    start_job(FIFO_DEPTH, 2, 1'b1, 0); finish_job(FIFO_DEPTH, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wino_pass_scheduler.md
Name: wino_pass_scheduler

Overview:
- Sequences one Winograd PE core job: streams T spatial tiles once per input-channel group, G groups per job.
- Drives the core's in_valid, tofifo, fromfifo, bias_valid and poolop so partial sums accumulate through the per-PE inter-FIFOs.
- Sits between the layer controller (configuration handshake) and the feature/weight buffers (tile-issue handshake).
- Tags core outputs so downstream stores only final-pass results.

Parameters:
- TILE_W, 11: width of tile count/index; supports T up to 1024.
- GRP_W, 8: width of group count/index.
- FIFO_DEPTH, 1024: inter-FIFO depth; the maximum legal T.
- MIN_PASS, 4: minimum cycles between the first issue of consecutive passes; a RAW guard for the FIFO.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cfg_valid  in  1  job configuration valid
- cfg_ready  out  1  scheduler idle; accepts configuration
- cfg_tiles  in  TILE_W  T, tiles per pass
- cfg_groups  in  GRP_W  G, channel groups per job
- cfg_poolop  in  1  pool enable for this job
- cfg_err  out  1  one-cycle pulse: configuration rejected
- issue_valid  out  1  request the next tile from the buffers
- issue_ready  in  1  buffers accept; data is presented on the following cycle
- issue_tile  out  TILE_W  tile index of the request
- issue_group  out  GRP_W  group index; also selects the weights
- pe_in_valid  out  1  core in_valid
- pe_tofifo  out  1  core tofifo
- pe_fromfifo  out  1  core fromfifo
- pe_bias_valid  out  1  core bias_valid
- pe_poolop  out  1  core poolop
- pe_out_valid  in  1  core out_valid
- res_keep  out  1  qualifies pe_out_valid as a final-pass result
- busy  out  1  job in progress
- done  out  1  one-cycle pulse: job complete and pipeline drained

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - All outputs are 0 during reset, except cfg_ready = 1 once out of reset.
  - State IDLE; all counters cleared.
  - Reset mid-job abandons the job with no done pulse. The core FIFOs share rst_n and are cleared together with the scheduler.
- States: IDLE, BIAS, ISSUE, GAP, DRAIN, DONE.
- IDLE:
  - cfg_ready = 1.
  - Configuration is accepted on cfg_valid & cfg_ready; T, G and poolop are latched.
  - If T == 0, G == 0, or T > FIFO_DEPTH: cfg_err pulses the next cycle and the state stays IDLE.
- BIAS: pe_bias_valid = 1 for exactly one cycle (the cycle after acceptance), then ISSUE.
- ISSUE:
  - issue_valid = 1, with issue_tile = t and issue_group = g.
  - On handshake, pe_in_valid = 1 on the next cycle (registered), together with:
    - pe_tofifo = (g != G-1)
    - pe_fromfifo = (g != 0)
  - Without a handshake, pe_in_valid = 0 that cycle; bubbles are legal and the flags are don't-care.
  - t advances on each handshake.
  - At t == T-1 with handshake:
    - if g == G-1: go to DRAIN;
    - else if (cycles since the pass's first issue + 1) < MIN_PASS: go to GAP;
    - else: stay in ISSUE with t = 0, g + 1.
- GAP: issue_valid = 0; hold until MIN_PASS cycles have elapsed since the pass's first issue, then ISSUE with g + 1.
- DRAIN:
  - No issues.
  - Wait until the output counter reaches T*G (width TILE_W+GRP_W), then DONE.
- DONE: done = 1 for one cycle, then IDLE.
- pe_poolop = latched cfg_poolop while busy; 0 otherwise.
- busy = 1 in every state except IDLE.
- Output counter:
  - Increments on every pe_out_valid while busy.
  - res_keep = pe_out_valid & (count >= T*(G-1)).
  - For G == 1, every output is kept.
- Stray pe_out_valid in IDLE is ignored; res_keep = 0.
- cfg_valid while busy is held off by cfg_ready = 0; there is no queueing.

Optional Feature:
- Macro: WINO_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_busy_cyc and perf_stall_cyc, each PERF_W bits.
  - perf_busy_cyc counts cycles with busy = 1.
  - perf_stall_cyc counts cycles in ISSUE with issue_valid & !issue_ready.
  - Both clear on job acceptance and saturate at all-ones.
- Undefined: the ports and the logic are absent.

Decomposition:
- Shared package:
  - State enum.
  - TILE_W, GRP_W, FIFO_DEPTH.
  - A pass-flag constant function: (g, G) -> {tofifo, fromfifo}, reused by the bench model.
- One sub-module, wino_out_tagger: the output counter and the res_keep compare.

Test Plan:
- T=4, G=1, issue_ready always 1: one bias pulse; 4 pe_in_valid with tofifo=0, fromfifo=0; 4 outputs, all with res_keep; done after the fourth output.
- T=8, G=3: pass flags are (tofifo=1, fromfifo=0), then (1,1), then (0,1); 24 outputs, res_keep on the last 8 only; issue_group sequence 0,1,2.
- T=1, G=3, MIN_PASS=4: first issues of consecutive passes are exactly 4 cycles apart; GAP entered; no FIFO read precedes the matching write.
- T=16, G=2 with issue_ready toggling 1010…: pe_in_valid mirrors the handshakes delayed by one cycle; tile order intact; done after 32 outputs.
- Config T=0, then T=1025, then cfg_valid while busy: cfg_err pulses for the first two cases and they stay IDLE; the third is held with cfg_ready=0 until DONE.
- rst_n low mid-pass 2 of a T=8, G=3 job: all pe_* outputs 0 on the next cycle; busy=0; no done pulse; a new job then completes normally.
